// File: rtl/wbuffer_pkg.sv
// Shared types for the 2x2 window buffer and its sequencer.
// The mode encoding is what the wbuffer decodes to select which register captures the byte.
package wbuffer_pkg;

  localparam int WB_ADDR_W = 16;
  localparam int WB_COL_W  = 10;

  typedef enum logic [2:0] {
    WB_IDLE  = 3'b000,
    WB_LD1   = 3'b001,
    WB_LD2   = 3'b010,
    WB_LD3   = 3'b011,
    WB_LD4   = 3'b100,
    WB_SHIFT = 3'b101
  } mode_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD1,
    S_LD2,
    S_LD3,
    S_LD4,
    S_EMIT,
    S_SHIFT,
    S_FIN
  } state_t;

endpackage

// File: rtl/wbuffer_ctrl.sv
// Sequencer for the 2x2 window buffer: fetches top-row pixels from SRAM and bottom-row
// pixels from SDRAM, then slides the window one column at a time along the row pair.
module wbuffer_ctrl
  import wbuffer_pkg::*;
#(
  parameter int ADDR_W = WB_ADDR_W,
  parameter int COL_W  = WB_COL_W
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic [COL_W-1:0]  row_width,
  input  logic [ADDR_W-1:0] sram_base,
  input  logic [ADDR_W-1:0] sdram_base,
  output logic              sram_req,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic              sram_ack,
  output logic              sdram_req,
  output logic [ADDR_W-1:0] sdram_addr,
  input  logic              sdram_ack,
  output logic              enable_CU,
  output logic [2:0]        mode,
  output logic              win_valid,
  input  logic              win_ready,
  output logic              busy,
  output logic              done
);

  state_t            state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [COL_W-1:0]  rowWidth_q, rowWidth_d;
  logic [ADDR_W-1:0] sramBase_q, sramBase_d;
  logic [ADDR_W-1:0] sdramBase_q, sdramBase_d;
  mode_t             modeSel;
  logic [ADDR_W-1:0] colAddr;
  logic              lastCol;

  assign colAddr = ADDR_W'(col_q);
  assign lastCol = (col_q == rowWidth_q - COL_W'(1));
  assign busy    = (state_q != S_IDLE);
  assign mode    = modeSel;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q     <= S_IDLE;
      col_q       <= '0;
      rowWidth_q  <= '0;
      sramBase_q  <= '0;
      sdramBase_q <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      rowWidth_q  <= rowWidth_d;
      sramBase_q  <= sramBase_d;
      sdramBase_q <= sdramBase_d;
    end
  end

  // Addresses are driven only while the matching request is up, so idle buses read as zero.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    rowWidth_d  = rowWidth_q;
    sramBase_d  = sramBase_q;
    sdramBase_d = sdramBase_q;
    sram_req    = 1'b0;
    sram_addr   = '0;
    sdram_req   = 1'b0;
    sdram_addr  = '0;
    enable_CU   = 1'b0;
    modeSel     = WB_IDLE;
    win_valid   = 1'b0;
    done        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          rowWidth_d  = row_width;
          sramBase_d  = sram_base;
          sdramBase_d = sdram_base;
          col_d       = '0;
          state_d     = (row_width < COL_W'(2)) ? S_FIN : S_LD1;
        end
      end
      S_LD1: begin
        sram_req  = 1'b1;
        sram_addr = sramBase_q + colAddr;
        if (sram_ack) begin
          enable_CU = 1'b1;
          modeSel   = WB_LD1;
          col_d     = col_q + COL_W'(1);
          state_d   = S_LD2;
        end
      end
      // Only the first window (col 1) still needs the bottom-left pixel; later ones get it by shifting.
      S_LD2: begin
        sram_req  = 1'b1;
        sram_addr = sramBase_q + colAddr;
        if (sram_ack) begin
          enable_CU = 1'b1;
          modeSel   = WB_LD2;
          state_d   = (col_q == COL_W'(1)) ? S_LD3 : S_LD4;
        end
      end
      S_LD3: begin
        sdram_req  = 1'b1;
        sdram_addr = sdramBase_q + colAddr - ADDR_W'(1);
        if (sdram_ack) begin
          enable_CU = 1'b1;
          modeSel   = WB_LD3;
          state_d   = S_LD4;
        end
      end
      S_LD4: begin
        sdram_req  = 1'b1;
        sdram_addr = sdramBase_q + colAddr;
        if (sdram_ack) begin
          enable_CU = 1'b1;
          modeSel   = WB_LD4;
          state_d   = S_EMIT;
        end
      end
      S_EMIT: begin
        win_valid = 1'b1;
        if (win_ready) begin
          state_d = lastCol ? S_FIN : S_SHIFT;
        end
      end
      S_SHIFT: begin
        enable_CU = 1'b1;
        modeSel   = WB_SHIFT;
        col_d     = col_q + COL_W'(1);
        state_d   = S_LD2;
      end
      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_wbuffer_ctrl.sv
// Self-checking bench for wbuffer_ctrl: randomized memory latency and consumer backpressure
// checked against a per-row list of expected captures and windows.
module tb_wbuffer_ctrl;

  localparam int AW = 16;
  localparam int CW = 10;

  // kind 0: SRAM capture, 1: SDRAM capture, 2: shift, 3: window emitted
  typedef struct packed {
    logic [1:0]    kind;
    logic [2:0]    mode;
    logic [AW-1:0] addr;
  } ev_t;

  logic          clk = 1'b0;
  logic          nrst;
  logic          start;
  logic [CW-1:0] row_width;
  logic [AW-1:0] sram_base, sdram_base;
  logic          sram_req, sram_ack, sdram_req, sdram_ack;
  logic [AW-1:0] sram_addr, sdram_addr;
  logic          enable_CU, win_valid, win_ready, busy, done;
  logic [2:0]    mode;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wbuffer_ctrl #(.ADDR_W(AW), .COL_W(CW)) dut (
    .clk(clk), .nrst(nrst), .start(start), .row_width(row_width),
    .sram_base(sram_base), .sdram_base(sdram_base),
    .sram_req(sram_req), .sram_addr(sram_addr), .sram_ack(sram_ack),
    .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_ack(sdram_ack),
    .enable_CU(enable_CU), .mode(mode), .win_valid(win_valid), .win_ready(win_ready),
    .busy(busy), .done(done)
  );

  task automatic quiet_inputs();
    start = 1'b0; sram_ack = 1'b0; sdram_ack = 1'b0; win_ready = 1'b0;
  endtask

  // Full row: expected captures come from the column walk, not from the controller's states.
  task automatic run_row(input string name, input int rw, input logic [AW-1:0] sb,
                         input logic [AW-1:0] db, input int minLat, input int maxLat,
                         input int secondWait, input int readyMax, input bit noise,
                         input bit checkTiming);
    ev_t q[$];
    ev_t ev;
    int  sLat = -1, dLat = -1, rCnt = -1, winIdx = 0, doneCount = 0;
    bit  finished = 0, ok;
    int  budget = 60 * rw + 60;

    for (int w = 0; w < rw - 1; w++) begin
      if (w == 0) begin
        q.push_back('{2'd0, 3'b001, sb});
        q.push_back('{2'd0, 3'b010, sb + AW'(1)});
        q.push_back('{2'd1, 3'b011, db});
        q.push_back('{2'd1, 3'b100, db + AW'(1)});
      end else begin
        q.push_back('{2'd2, 3'b101, AW'(0)});
        q.push_back('{2'd0, 3'b010, sb + AW'(w + 1)});
        q.push_back('{2'd1, 3'b100, db + AW'(w + 1)});
      end
      q.push_back('{2'd3, 3'b000, AW'(0)});
    end

    @(posedge clk); #1;
    start = 1'b1; row_width = CW'(rw); sram_base = sb; sdram_base = db;

    for (int cyc = 0; cyc < budget && !finished; cyc++) begin
      @(posedge clk); #1;
      quiet_inputs();
      if (noise) begin
        start = 1'(($urandom_range(1, 0)));
        row_width = CW'($urandom_range(9, 0));
        sram_base = AW'($urandom);
        sdram_base = AW'($urandom);
      end
      if (sram_req) begin
        if (sLat < 0) sLat = $urandom_range(maxLat, minLat);
        if (sLat == 0) begin sram_ack = 1'b1; sLat = -1; end else sLat--;
      end else if (noise) sram_ack = 1'(($urandom_range(1, 0)));
      if (sdram_req) begin
        if (dLat < 0) dLat = $urandom_range(maxLat, minLat);
        if (dLat == 0) begin sdram_ack = 1'b1; dLat = -1; end else dLat--;
      end else if (noise) sdram_ack = 1'(($urandom_range(1, 0)));
      if (win_valid) begin
        if (rCnt < 0) rCnt = (winIdx == 1 && secondWait >= 0) ? secondWait : $urandom_range(readyMax, 0);
        if (rCnt == 0) begin win_ready = 1'b1; rCnt = -1; end else rCnt--;
      end else if (noise) win_ready = 1'(($urandom_range(1, 0)));
      #1;

      checks++;
      if (busy !== 1'b1) begin
        errors++; $display("[TB] FAIL %s busy cyc %0d got %b exp 1", name, cyc, busy);
      end
      checks++;
      if (sram_req && sdram_req) begin
        errors++; $display("[TB] FAIL %s both_req cyc %0d got 11 exp at most one", name, cyc);
      end
      if (sram_req) begin
        checks++;
        if (q.size() == 0 || q[0].kind != 2'd0 || sram_addr !== q[0].addr) begin
          errors++;
          $display("[TB] FAIL %s sram_req cyc %0d got addr %h exp %s", name, cyc, sram_addr,
                   (q.size() != 0 && q[0].kind == 2'd0) ? $sformatf("addr %h", q[0].addr) : "no request");
        end
      end
      if (sdram_req) begin
        checks++;
        if (q.size() == 0 || q[0].kind != 2'd1 || sdram_addr !== q[0].addr) begin
          errors++;
          $display("[TB] FAIL %s sdram_req cyc %0d got addr %h exp %s", name, cyc, sdram_addr,
                   (q.size() != 0 && q[0].kind == 2'd1) ? $sformatf("addr %h", q[0].addr) : "no request");
        end
      end
      if (enable_CU) begin
        checks++;
        if (q.size() == 0 || q[0].kind == 2'd3) begin
          errors++; $display("[TB] FAIL %s enable cyc %0d got mode %b exp no write", name, cyc, mode);
        end else begin
          ev = q.pop_front();
          case (ev.kind)
            2'd0:    ok = sram_req && sram_ack;
            2'd1:    ok = sdram_req && sdram_ack;
            default: ok = !sram_req && !sdram_req;
          endcase
          if (!ok || mode !== ev.mode) begin
            errors++;
            $display("[TB] FAIL %s capture cyc %0d got mode %b ack %b%b exp mode %b kind %0d",
                     name, cyc, mode, sram_ack, sdram_ack, ev.mode, ev.kind);
          end
        end
      end else begin
        checks++;
        if (mode !== 3'b000 || (sram_req && sram_ack) || (sdram_req && sdram_ack)) begin
          errors++;
          $display("[TB] FAIL %s no_enable cyc %0d got mode %b ack %b%b exp mode 000 and no acked req",
                   name, cyc, mode, sram_ack, sdram_ack);
        end
      end
      if (win_valid) begin
        checks++;
        if (q.size() == 0 || q[0].kind != 2'd3 || sram_req || sdram_req) begin
          errors++; $display("[TB] FAIL %s win_valid cyc %0d got early or with req exp complete window", name, cyc);
        end else if (win_ready) begin
          void'(q.pop_front());
          if (checkTiming) begin
            checks++;
            if (cyc !== 4 + 4 * winIdx) begin
              errors++; $display("[TB] FAIL %s win_timing got cyc %0d exp %0d", name, cyc, 4 + 4 * winIdx);
            end
          end
          winIdx++;
        end
      end
      if (done) begin
        checks++;
        doneCount++;
        finished = 1;
        if (q.size() != 0) begin
          errors++; $display("[TB] FAIL %s early_done cyc %0d got %0d events left exp 0", name, cyc, q.size());
        end
        if (checkTiming && rw < 2) begin
          checks++;
          if (cyc > 1) begin
            errors++; $display("[TB] FAIL %s short_done got cyc %0d exp at most 1", name, cyc);
          end
        end
      end
    end
    quiet_inputs();

    checks++;
    if (doneCount != 1 || winIdx != rw - 1 && rw >= 2) begin
      errors++; $display("[TB] FAIL %s completion got done %0d windows %0d exp 1 and %0d", name,
                         doneCount, winIdx, (rw >= 2) ? rw - 1 : 0);
    end
    @(posedge clk); #2;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("[TB] FAIL %s after_done got busy %b done %b exp 0 0", name, busy, done);
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0; quiet_inputs();
    row_width = '0; sram_base = '0; sdram_base = '0;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if ({sram_req, sdram_req, enable_CU, win_valid, busy, done} !== 6'b0 || mode !== 3'b000 ||
        sram_addr !== '0 || sdram_addr !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got req %b%b en %b mode %b valid %b busy %b done %b exp all 0",
               sram_req, sdram_req, enable_CU, mode, win_valid, busy, done);
    end
    nrst = 1'b1;
  endtask

  task automatic test_basic();
    run_row("basic", 4, 16'h0100, 16'h0200, 0, 0, -1, 0, 1'b0, 1'b1);
  endtask

  task automatic test_delayed_ack();
    run_row("delayed", 4, 16'h0100, 16'h0200, 3, 3, -1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_row("backpressure", 4, 16'h0100, 16'h0200, 0, 1, 5, 0, 1'b0, 1'b0);
  endtask

  task automatic test_short_row();
    run_row("short_row1", 1, 16'h0100, 16'h0200, 0, 0, -1, 0, 1'b0, 1'b1);
    run_row("short_row0", 0, 16'h0500, 16'h0600, 0, 0, -1, 0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_midrun();
    bit seen = 0;
    @(posedge clk); #1;
    start = 1'b1; row_width = CW'(5); sram_base = 16'h0300; sdram_base = 16'h0400;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      sram_ack = sram_req;
      if (sdram_req) seen = 1;
    end
    sram_ack = 1'b0;
    checks++;
    if (!seen) begin
      errors++; $display("[TB] FAIL midrun_reach got no sdram_req exp sdram_req within 20 cycles");
    end
    nrst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({sram_req, sdram_req, enable_CU, win_valid, busy, done} !== 6'b0 || mode !== 3'b000) begin
      errors++;
      $display("[TB] FAIL midrun_reset got req %b%b en %b valid %b busy %b done %b exp all 0",
               sram_req, sdram_req, enable_CU, win_valid, busy, done);
    end
    nrst = 1'b1;
    run_row("after_reset", 3, 16'h0700, 16'h0800, 0, 0, -1, 0, 1'b0, 1'b1);
  endtask

  task automatic test_noise();
    run_row("noise", 5, 16'h1000, 16'h2000, 0, 2, -1, 3, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    run_row("wrap", 4, 16'hFFFE, 16'hFFFF, 0, 3, -1, 2, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      run_row($sformatf("random%0d", i), $urandom_range(7, 2), AW'($urandom), AW'($urandom),
              0, 3, -1, 3, 1'(i[0]), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_delayed_ack();
    test_backpressure();
    test_short_row();
    test_reset_midrun();
    test_noise();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
